// File: rtl/day_9_rr_arbiter_bin_pkg.sv
// Shared constants and FSM state type for the 16-way round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package day_9_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/day_9_rr_arbiter_bin_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Latency: none (wiring only).
// Backpressure: gnt_ready_i from the grant consumer stalls gnt_valid_o/gnt_idx_o.
interface day_9_rr_arbiter_bin_if;
  import day_9_arb_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic               gnt_ready_i;
  logic               gnt_valid_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               busy_o;

  // Arbiter side.
  modport master (
    input  req_i,
    input  gnt_ready_i,
    output gnt_valid_o,
    output gnt_idx_o,
    output busy_o
  );

  // Requester / grant-consumer side.
  modport slave (
    output req_i,
    output gnt_ready_i,
    input  gnt_valid_o,
    input  gnt_idx_o,
    input  busy_o
  );

endinterface

// File: rtl/day_9_rr_arbiter_bin_pick.sv
// Circular first-set search of req starting at ptr, returning a binary index.
// Latency: combinational.
// Backpressure: none; idx is meaningless when any_o is low.
module day_9_rr_pick
  import day_9_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] shifted;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate right so bit ptr lands at position 0; the doubled vector makes the shift wrap.
  assign dbl     = {req, req};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[NUM_REQ-1:0];
  assign any_o   = |req;

  // Lowest set bit of the rotated vector; scanning downward lets the last hit win.
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Undo the rotation; 4-bit addition wraps modulo 16.
  assign idx = off + ptr;

endmodule

// File: rtl/day_9_rr_arbiter_bin.sv
// Round-robin arbiter over 16 requesters with a registered binary grant index.
// Latency: 1 cycle from request to gnt_valid_o; back-to-back grants at one per cycle.
// Backpressure: grant held stable (never retracted) while gnt_ready_i is low; ptr only moves on handshake.
module day_9_rr_arbiter_bin
  import day_9_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  day_9_rr_arbiter_bin_if.master arb
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             busy;

  logic [IDX_W-1:0] after_gnt;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             handshake;

  assign after_gnt = gnt_idx + IDX_W'(1);
  assign handshake = gnt_valid & arb.gnt_ready_i;

  // In GRANT the search must start just past the current grant, which is what ptr becomes on handshake.
  assign pick_ptr = (state == GRANT) ? after_gnt : ptr;

  day_9_rr_pick u_pick (
    .req   (arb.req_i),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .any_o (pick_any)
  );

  // FSM with registered grant outputs; busy tracks the next state so it always equals gnt_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (handshake) begin
            ptr <= after_gnt;
            if (pick_any) begin
              gnt_idx <= pick_idx;
            end else begin
              gnt_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign arb.gnt_valid_o = gnt_valid;
  assign arb.gnt_idx_o   = gnt_idx;
  assign arb.busy_o      = busy;

endmodule

// File: tb/tb_day_9_rr_arbiter_bin.sv
// Self-checking bench for the 16-way round-robin arbiter.
// Latency: expects grants one cycle after the driving edge.
// Backpressure: exercises stalls, mid-stall request changes and async reset under stall.
module tb_day_9_rr_arbiter_bin;
  import day_9_arb_pkg::*;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errs;
  int   checks;

  exp_t exp_q[$];

  // Reference model state
  logic             m_vld;
  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] m_ptr;

  day_9_rr_arbiter_bin_if arb_if ();

  day_9_rr_arbiter_bin dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (arb_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [IDX_W-1:0] ref_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) r = IDX_W'(j);
    end
    return r;
  endfunction

  // Advance the model by one clock edge and queue what the DUT should show after it.
  task automatic model_step(input logic [NUM_REQ-1:0] req, input logic rdy);
    exp_t e;
    if (!m_vld) begin
      if (|req) begin
        m_idx = ref_pick(req, m_ptr);
        m_vld = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = m_idx + 4'd1;
      if (|req) m_idx = ref_pick(req, m_ptr);
      else      m_vld = 1'b0;
    end
    e.vld = m_vld;
    e.idx = m_idx;
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_vld"},  int'(arb_if.gnt_valid_o), int'(e.vld));
    chk({tag, "_idx"},  int'(arb_if.gnt_idx_o),   int'(e.idx));
    chk({tag, "_busy"}, int'(arb_if.busy_o),      int'(e.vld));
  endtask

  task automatic cyc(input string tag, input logic [NUM_REQ-1:0] req, input logic rdy);
    @(negedge clk);
    arb_if.req_i       = req;
    arb_if.gnt_ready_i = rdy;
    model_step(req, rdy);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_idx = '0;
    m_ptr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n            = 1'b0;
    arb_if.req_i       = '0;
    arb_if.gnt_ready_i = 1'b0;
    model_reset();
    #1;
    chk("rst_vld",  int'(arb_if.gnt_valid_o), 0);
    chk("rst_idx",  int'(arb_if.gnt_idx_o),   0);
    chk("rst_busy", int'(arb_if.busy_o),      0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Pulse reset between edges, check the asynchronous clear, then let the next edge grant from ptr 0.
  task automatic reset_pulse(input logic [NUM_REQ-1:0] req, input logic rdy);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_vld",  int'(arb_if.gnt_valid_o), 0);
    chk("async_rst_idx",  int'(arb_if.gnt_idx_o),   0);
    chk("async_rst_busy", int'(arb_if.busy_o),      0);
    arb_if.req_i       = req;
    arb_if.gnt_ready_i = rdy;
    model_reset();
    #1;
    reset_n = 1'b1;
    model_step(req, rdy);
    @(posedge clk);
    #1;
    compare_out("post_rst");
  endtask

  initial begin
    errs               = 0;
    checks             = 0;
    reset_n            = 1'b0;
    arb_if.req_i       = '0;
    arb_if.gnt_ready_i = 1'b0;
    model_reset();
    #12;
    chk("init_vld",  int'(arb_if.gnt_valid_o), 0);
    chk("init_idx",  int'(arb_if.gnt_idx_o),   0);
    chk("init_busy", int'(arb_if.busy_o),      0);
    reset_n = 1'b1;

    // Idle: no requests, nothing granted.
    for (int i = 0; i < 5; i++) cyc("idle", 16'h0000, 1'b1);

    // Sole requester re-granted every cycle.
    for (int i = 0; i < 4; i++) cyc("sole", 16'h0001, 1'b1);

    // Two requesters at opposite ends alternate 0,15,... with valid held.
    do_reset();
    for (int i = 0; i < 6; i++) cyc("pair", 16'h8001, 1'b1);

    // All requesting: full 0..15 rotation and wrap.
    do_reset();
    for (int i = 0; i < 18; i++) cyc("all", 16'hFFFF, 1'b1);
    chk("all_final_idx", int'(arb_if.gnt_idx_o), 1);

    // Stall on grant 4; a new lower-index request must not retract it.
    do_reset();
    for (int i = 0; i < 3; i++) cyc("stall", 16'h0030, 1'b0);
    chk("stall_idx4", int'(arb_if.gnt_idx_o), 4);
    for (int i = 0; i < 2; i++) cyc("stall_chg", 16'h0031, 1'b0);
    chk("stall_keep4", int'(arb_if.gnt_idx_o), 4);
    cyc("release", 16'h0031, 1'b1);
    chk("release_idx5", int'(arb_if.gnt_idx_o), 5);
    cyc("release", 16'h0031, 1'b1);
    chk("release_idx0", int'(arb_if.gnt_idx_o), 0);
    cyc("drain", 16'h0000, 1'b1);

    // Async reset while stalled on grant 4.
    do_reset();
    for (int i = 0; i < 2; i++) cyc("pre_pulse", 16'h0030, 1'b0);
    reset_pulse(16'h0011, 1'b0);
    chk("post_rst_idx0", int'(arb_if.gnt_idx_o), 0);
    cyc("post_rst_hs", 16'h0011, 1'b1);

    // Random traffic, including ready while idle.
    for (int i = 0; i < 300; i++) begin
      logic [NUM_REQ-1:0] r;
      logic               rd;
      r  = ($urandom_range(0, 3) == 0) ? 16'h0000 : NUM_REQ'($urandom & $urandom);
      rd = ($urandom_range(0, 2) != 0);
      cyc("rand", r, rd);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
